// File: rtl/uart_tx_arb.sv
// Two-requester byte arbiter in front of a UART TX, plus an RX holding register.
// Define UART_TX_ARB_PRIO_EN for fixed priority (req0 wins ties); default is round-robin.
module uart_tx_arb #(
   parameter int unsigned TMO_CYCLES = 16,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_en,
   input  logic       i_req0_valid,
   input  logic [7:0] i_req0_data,
   output logic       o_req0_ready,
   input  logic       i_req1_valid,
   input  logic [7:0] i_req1_data,
   output logic       o_req1_ready,
   output logic       o_uart_en,
   output logic       o_uart_str_tx,
   output logic [7:0] o_uart_data_tx,
   input  logic       i_uart_busy_tx,
   input  logic       i_uart_rxne,
   input  logic [7:0] i_uart_data_rx,
   output logic       o_rx_valid,
   output logic [7:0] o_rx_data,
   input  logic       i_rx_ack,
   output logic       o_rx_ovr,
   output logic       o_owner,
   output logic       o_tmo_err
);

   localparam int unsigned TMO_W = $clog2(TMO_CYCLES + 1);
   localparam int unsigned CNT_W = (TMO_W > 4) ? TMO_W : 4;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_DONE,
      S_GAP
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             any_valid;
   logic             grant;
   logic             accept;
   logic             tmo_hit;
   logic             rxne_q;
   logic             rx_edge;

`ifndef UART_TX_ARB_PRIO_EN
   logic             last_served;
`endif

   assign any_valid = i_req0_valid | i_req1_valid;

   // grant = 1 selects requester 1
   always_comb begin
`ifdef UART_TX_ARB_PRIO_EN
      grant = ~i_req0_valid;
`else
      if (i_req0_valid && i_req1_valid) grant = ~last_served;
      else                              grant = ~i_req0_valid;
`endif
   end

   assign accept       = i_rst && i_en && (state == S_IDLE) && any_valid;
   assign o_req0_ready = accept & ~grant;
   assign o_req1_ready = accept &  grant;
   assign o_uart_en    = i_en;
   assign o_uart_str_tx = i_en && ((state == S_ISSUE) || (state == S_WAIT_DONE));

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      tmo_hit   = 1'b0;
      case (state)
         S_IDLE: begin
            if (any_valid) begin
               state_nxt = S_ISSUE;
               cnt_nxt   = '0;
            end
         end
         S_ISSUE: begin
            if (i_uart_busy_tx) begin
               state_nxt = S_WAIT_DONE;
            end else if (cnt == TMO_LAST) begin
               tmo_hit   = 1'b1;
               state_nxt = S_GAP;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_WAIT_DONE: begin
            if (!i_uart_busy_tx) begin
               state_nxt = S_GAP;
               cnt_nxt   = '0;
            end
         end
         S_GAP: begin
            if (cnt == GAP_LAST) state_nxt = S_IDLE;
            else                 cnt_nxt   = cnt + CNT_W'(1);
         end
         default: state_nxt = S_IDLE;
      endcase
      if (!i_en) begin
         state_nxt = S_IDLE;
         cnt_nxt   = '0;
         tmo_hit   = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         o_uart_data_tx <= '0;
         o_owner        <= 1'b0;
         o_tmo_err      <= 1'b0;
`ifndef UART_TX_ARB_PRIO_EN
         last_served    <= 1'b1;
`endif
      end else begin
         if (accept) begin
            o_uart_data_tx <= grant ? i_req1_data : i_req0_data;
            o_owner        <= grant;
`ifndef UART_TX_ARB_PRIO_EN
            last_served    <= grant;
`endif
         end
         if (tmo_hit) o_tmo_err <= 1'b1;
      end
   end

   // RX edge tracking keeps running while disabled so re-enable cannot fake an edge
   assign rx_edge = i_uart_rxne & ~rxne_q;

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         rxne_q     <= 1'b0;
         o_rx_valid <= 1'b0;
         o_rx_data  <= '0;
         o_rx_ovr   <= 1'b0;
      end else begin
         rxne_q <= i_uart_rxne;
         if (!i_en) begin
            o_rx_valid <= 1'b0;
            o_rx_ovr   <= 1'b0;
         end else if (rx_edge) begin
            o_rx_data <= i_uart_data_rx;
            if (!o_rx_valid || i_rx_ack) begin
               o_rx_valid <= 1'b1;
               o_rx_ovr   <= 1'b0;
            end else begin
               o_rx_ovr   <= 1'b1;
            end
         end else if (i_rx_ack) begin
            o_rx_valid <= 1'b0;
            o_rx_ovr   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed scenarios plus randomized TX/RX traffic
// checked against a transaction-level model; honours UART_TX_ARB_PRIO_EN.
module tb_uart_tx_arb;

   localparam int unsigned TMO = 16;
   localparam int unsigned GAP = 2;
`ifdef UART_TX_ARB_PRIO_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   logic       i_clk = 1'b0;
   logic       i_rst, i_en;
   logic       i_req0_valid, i_req1_valid;
   logic [7:0] i_req0_data, i_req1_data;
   logic       o_req0_ready, o_req1_ready;
   logic       o_uart_en, o_uart_str_tx;
   logic [7:0] o_uart_data_tx;
   logic       i_uart_busy_tx;
   logic       i_uart_rxne;
   logic [7:0] i_uart_data_rx;
   logic       o_rx_valid, o_rx_ovr, i_rx_ack;
   logic [7:0] o_rx_data;
   logic       o_owner, o_tmo_err;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   logic       s_r0, s_r1, s_str, s_en, s_owner, s_rxv, s_ovr, s_tmo;
   logic [7:0] s_data, s_rxd;

   // UART busy responder: one busy pulse of busy_len cycles per frame (0 = never busy)
   int unsigned busy_len = 0;
   int unsigned busy_rem = 0;
   logic        busy_done = 1'b0;

   uart_tx_arb #(.TMO_CYCLES(TMO), .GAP_CYCLES(GAP)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en),
      .i_req0_valid(i_req0_valid), .i_req0_data(i_req0_data), .o_req0_ready(o_req0_ready),
      .i_req1_valid(i_req1_valid), .i_req1_data(i_req1_data), .o_req1_ready(o_req1_ready),
      .o_uart_en(o_uart_en), .o_uart_str_tx(o_uart_str_tx), .o_uart_data_tx(o_uart_data_tx),
      .i_uart_busy_tx(i_uart_busy_tx), .i_uart_rxne(i_uart_rxne), .i_uart_data_rx(i_uart_data_rx),
      .o_rx_valid(o_rx_valid), .o_rx_data(o_rx_data), .i_rx_ack(i_rx_ack), .o_rx_ovr(o_rx_ovr),
      .o_owner(o_owner), .o_tmo_err(o_tmo_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic step();
      logic nb;
      nb = 1'b0;
      #1;
      s_r0 = o_req0_ready;  s_r1 = o_req1_ready;  s_str = o_uart_str_tx;
      s_en = o_uart_en;     s_data = o_uart_data_tx; s_owner = o_owner;
      s_rxv = o_rx_valid;   s_rxd = o_rx_data;    s_ovr = o_rx_ovr;  s_tmo = o_tmo_err;
      if (busy_rem > 0) begin
         busy_rem--;
         nb = (busy_rem > 0);
      end else if (s_str && !busy_done && busy_len > 0) begin
         nb        = 1'b1;
         busy_rem  = busy_len;
         busy_done = 1'b1;
      end
      if (!s_str) busy_done = 1'b0;
      @(posedge i_clk);
      #1;
      i_uart_busy_tx = nb;
   endtask

   task automatic do_reset();
      i_rst = 1'b0; i_en = 1'b1;
      i_req0_valid = 1'b0; i_req1_valid = 1'b0;
      i_uart_rxne = 1'b0; i_rx_ack = 1'b0;
      busy_len = 0; busy_rem = 0; busy_done = 1'b0; i_uart_busy_tx = 1'b0;
      step();
      i_rst = 1'b1;
   endtask

   task automatic test_reset();
      i_en = 1'b1; i_rst = 1'b0; i_uart_busy_tx = 1'b0; i_uart_rxne = 1'b0; i_rx_ack = 1'b0;
      i_req0_valid = 1'b1; i_req0_data = 8'hA5; i_req1_valid = 1'b1; i_req1_data = 8'h5A;
      step();
      n_cmp++;
      if ({s_r1, s_r0} !== 2'b00) begin n_bad++; $display("FAIL reset_ready: got %b%b want 00", s_r1, s_r0); end
      i_rst = 1'b1; i_req0_valid = 1'b0; i_req1_valid = 1'b0;
      step();
      n_cmp++;
      if ({s_str, s_owner, s_rxv, s_ovr, s_tmo} !== 5'b0) begin
         n_bad++; $display("FAIL reset_flags: got str/own/rxv/ovr/tmo=%b want 00000", {s_str, s_owner, s_rxv, s_ovr, s_tmo});
      end
      n_cmp++;
      if (s_data !== 8'h00) begin n_bad++; $display("FAIL reset_data_tx: got %h want 00", s_data); end
      n_cmp++;
      if (s_rxd !== 8'h00) begin n_bad++; $display("FAIL reset_rx_data: got %h want 00", s_rxd); end
      n_cmp++;
      if (s_en !== 1'b1) begin n_bad++; $display("FAIL reset_uart_en: got %b want 1", s_en); end
   endtask

   task automatic test_single_req();
      int unsigned hi, lo;
      logic bad_data, got;
      do_reset();
      busy_len = 20;
      i_req0_valid = 1'b1; i_req0_data = 8'h41;
      step();
      n_cmp++;
      if ({s_r1, s_r0} !== 2'b01) begin n_bad++; $display("FAIL single_ready: got %b%b want 01", s_r1, s_r0); end
      i_req0_valid = 1'b0;
      hi = 0; bad_data = 1'b0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (!s_str) break;
         hi++;
         if (s_data !== 8'h41 || s_r0 || s_r1) bad_data = 1'b1;
      end
      n_cmp++;
      if (hi !== 22) begin n_bad++; $display("FAIL single_str_len: got %0d want 22", hi); end
      n_cmp++;
      if (bad_data !== 1'b0) begin n_bad++; $display("FAIL single_data_stable: got unstable want 41 held"); end
      i_req0_valid = 1'b1; i_req0_data = 8'h42;
      lo = 1; got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (s_r0) begin got = 1'b1; break; end
         if (s_str) break;
         lo++;
      end
      n_cmp++;
      if (!got || lo !== GAP || s_data !== 8'h41) begin
         n_bad++; $display("FAIL single_gap: got ready=%b gap=%0d data=%h want 1 %0d 41", got, lo, s_data, GAP);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_seq;
      logic       chk, expg;
      logic [7:0] expd;
      int unsigned k;
      do_reset();
      busy_len = 3;
      exp_seq = PRIO ? 4'b0000 : 4'b1010;
      i_req0_valid = 1'b1; i_req0_data = 8'h10; i_req1_valid = 1'b1; i_req1_data = 8'h20;
      k = 0; chk = 1'b0; expd = 8'h00;
      for (int i = 0; i < 200 && k < 4; i++) begin
         step();
         if (chk) begin
            chk = 1'b0;
            n_cmp++;
            if (s_data !== expd) begin n_bad++; $display("FAIL rr_data[%0d]: got %h want %h", k - 1, s_data, expd); end
         end
         if (s_r0 | s_r1) begin
            expg = exp_seq[k];
            n_cmp++;
            if ({s_r1, s_r0} !== {expg, ~expg}) begin
               n_bad++; $display("FAIL rr_grant[%0d]: got %b%b want %b%b", k, s_r1, s_r0, expg, ~expg);
            end
            expd = expg ? 8'h20 : 8'h10;
            chk = 1'b1;
            k++;
         end
      end
      n_cmp++;
      if (k !== 4) begin n_bad++; $display("FAIL rr_count: got %0d grants want 4", k); end
   endtask

   task automatic test_timeout();
      int unsigned hi, lo;
      logic got;
      do_reset();
      busy_len = 0;
      i_req1_valid = 1'b1; i_req1_data = 8'h55;
      step();
      n_cmp++;
      if ({s_r1, s_r0} !== 2'b10) begin n_bad++; $display("FAIL tmo_ready: got %b%b want 10", s_r1, s_r0); end
      i_req1_valid = 1'b0;
      hi = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (i == 0) begin
            n_cmp++;
            if ({s_owner, s_tmo} !== 2'b10) begin n_bad++; $display("FAIL tmo_owner_err: got %b%b want 10", s_owner, s_tmo); end
         end
         if (!s_str) break;
         hi++;
      end
      n_cmp++;
      if (hi !== TMO) begin n_bad++; $display("FAIL tmo_str_len: got %0d want %0d", hi, TMO); end
      n_cmp++;
      if (s_tmo !== 1'b1) begin n_bad++; $display("FAIL tmo_err_set: got %b want 1", s_tmo); end
      i_req1_valid = 1'b1; i_req1_data = 8'h56;
      lo = 1; got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (s_r1) begin got = 1'b1; break; end
         if (s_str) break;
         lo++;
      end
      n_cmp++;
      if (!got || lo !== GAP) begin n_bad++; $display("FAIL tmo_gap: got ready=%b gap=%0d want 1 %0d", got, lo, GAP); end
   endtask

   task automatic test_random_tx();
      logic p0 = 1'b0, p1 = 1'b0, last = 1'b1, in_frame = 1'b0;
      logic exp_owner = 1'b0, exp_tmo = 1'b0, exp_any, win;
      logic [7:0] d0 = 8'h00, d1 = 8'h00, exp_data = 8'h00;
      int unsigned low = 255, hi = 0, exp_run = 0;
      do_reset();
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if (!p0 && $urandom_range(0, 3) == 0) begin p0 = 1'b1; d0 = 8'($urandom); end
         if (!p1 && $urandom_range(0, 3) == 0) begin p1 = 1'b1; d1 = 8'($urandom); end
         i_req0_valid = p0; i_req0_data = d0; i_req1_valid = p1; i_req1_data = d1;
         step();
         n_cmp++;
         if (s_data !== exp_data || s_owner !== exp_owner) begin
            n_bad++; $display("FAIL rnd_data: got %h/%b want %h/%b", s_data, s_owner, exp_data, exp_owner);
         end
         exp_any = !in_frame && low >= GAP && (p0 || p1);
         n_cmp++;
         if ((s_r0 | s_r1) !== exp_any || (s_r0 & s_r1)) begin
            n_bad++; $display("FAIL rnd_ready: got %b%b want any=%b", s_r1, s_r0, exp_any);
         end
         if (exp_any) begin
            win = (p0 && p1) ? (PRIO ? 1'b0 : ~last) : p1;
            n_cmp++;
            if (s_r1 !== win) begin n_bad++; $display("FAIL rnd_winner: got %b want %b", s_r1, win); end
            last = win; exp_owner = win; exp_data = win ? d1 : d0;
            if (win) p1 = 1'b0; else p0 = 1'b0;
            in_frame = 1'b1; hi = 0;
            busy_len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
            exp_run  = (busy_len == 0) ? TMO : busy_len + 2;
         end else if (in_frame) begin
            if (s_str) hi++;
            else begin
               n_cmp++;
               if (hi !== exp_run) begin n_bad++; $display("FAIL rnd_run: got %0d want %0d", hi, exp_run); end
               if (busy_len == 0) exp_tmo = 1'b1;
               in_frame = 1'b0; low = 1;
            end
         end else begin
            n_cmp++;
            if (s_str !== 1'b0) begin n_bad++; $display("FAIL rnd_str_idle: got %b want 0", s_str); end
            if (low < 255) low++;
         end
         n_cmp++;
         if (s_tmo !== exp_tmo) begin n_bad++; $display("FAIL rnd_tmo: got %b want %b", s_tmo, exp_tmo); end
      end
   endtask

   task automatic test_rx();
      logic mv, mo, prev;
      logic [7:0] md;
      int unsigned hl;
      do_reset();
      i_uart_rxne = 1'b1; i_uart_data_rx = 8'h33; step(); step();
      i_uart_rxne = 1'b0; step();
      n_cmp++;
      if ({s_rxv, s_ovr, s_rxd} !== {2'b10, 8'h33}) begin n_bad++; $display("FAIL rx_first: got v%b o%b %h want v1 o0 33", s_rxv, s_ovr, s_rxd); end
      i_uart_rxne = 1'b1; i_uart_data_rx = 8'h44; step();
      i_uart_rxne = 1'b0; step();
      n_cmp++;
      if ({s_rxv, s_ovr, s_rxd} !== {2'b11, 8'h44}) begin n_bad++; $display("FAIL rx_overrun: got v%b o%b %h want v1 o1 44", s_rxv, s_ovr, s_rxd); end
      i_rx_ack = 1'b1; step();
      i_rx_ack = 1'b0; step();
      n_cmp++;
      if ({s_rxv, s_ovr} !== 2'b00) begin n_bad++; $display("FAIL rx_ack_clear: got v%b o%b want v0 o0", s_rxv, s_ovr); end
      i_uart_rxne = 1'b1; i_uart_data_rx = 8'h66; step();
      i_uart_rxne = 1'b0; step();
      i_uart_rxne = 1'b1; i_uart_data_rx = 8'h77; i_rx_ack = 1'b1; step();
      i_uart_rxne = 1'b0; i_rx_ack = 1'b0; step();
      n_cmp++;
      if ({s_rxv, s_ovr, s_rxd} !== {2'b10, 8'h77}) begin n_bad++; $display("FAIL rx_ack_capture: got v%b o%b %h want v1 o0 77", s_rxv, s_ovr, s_rxd); end
      mv = 1'b1; mo = 1'b0; md = 8'h77; prev = 1'b0; hl = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (i_uart_rxne) begin
            if (hl < 2 && $urandom_range(0, 1) == 1) hl++;
            else i_uart_rxne = 1'b0;
         end else if ($urandom_range(0, 2) == 0) begin
            i_uart_rxne = 1'b1; hl = 1; i_uart_data_rx = 8'($urandom);
         end
         i_rx_ack = ($urandom_range(0, 3) == 0);
         step();
         n_cmp++;
         if ({s_rxv, s_ovr, s_rxd} !== {mv, mo, md}) begin
            n_bad++; $display("FAIL rx_rand: got v%b o%b %h want v%b o%b %h", s_rxv, s_ovr, s_rxd, mv, mo, md);
         end
         if (i_uart_rxne && !prev) begin
            md = i_uart_data_rx;
            if (!mv || i_rx_ack) begin mv = 1'b1; mo = 1'b0; end
            else mo = 1'b1;
         end else if (i_rx_ack) begin
            mv = 1'b0; mo = 1'b0;
         end
         prev = i_uart_rxne;
      end
      i_uart_rxne = 1'b0; i_rx_ack = 1'b0;
   endtask

   task automatic test_enable();
      logic [1:0] exp_sel;
      do_reset();
      busy_len = 10;
      i_uart_rxne = 1'b1; i_uart_data_rx = 8'h99; i_req0_valid = 1'b1; i_req0_data = 8'h5A;
      step();
      n_cmp++;
      if ({s_r1, s_r0} !== 2'b01) begin n_bad++; $display("FAIL en_ready: got %b%b want 01", s_r1, s_r0); end
      i_uart_rxne = 1'b0; i_req0_valid = 1'b0;
      for (int i = 0; i < 5; i++) step();
      n_cmp++;
      if (s_str !== 1'b1) begin n_bad++; $display("FAIL en_str_before: got %b want 1", s_str); end
      i_en = 1'b0; i_req0_valid = 1'b1; i_req0_data = 8'hB1; i_req1_valid = 1'b1; i_req1_data = 8'hA7;
      step();
      n_cmp++;
      if ({s_en, s_str, s_r1, s_r0} !== 4'b0000) begin n_bad++; $display("FAIL en_off_outputs: got %b want 0000", {s_en, s_str, s_r1, s_r0}); end
      i_en = 1'b1;
      step();
      exp_sel = PRIO ? 2'b01 : 2'b10;
      n_cmp++;
      if ({s_r1, s_r0} !== exp_sel) begin n_bad++; $display("FAIL en_restart_grant: got %b%b want %b", s_r1, s_r0, exp_sel); end
      n_cmp++;
      if ({s_str, s_data} !== {1'b0, 8'h5A}) begin n_bad++; $display("FAIL en_data_kept: got str%b %h want str0 5a", s_str, s_data); end
      n_cmp++;
      if ({s_rxv, s_ovr, s_rxd} !== {2'b00, 8'h99}) begin n_bad++; $display("FAIL en_rx_cleared: got v%b o%b %h want v0 o0 99", s_rxv, s_ovr, s_rxd); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      busy_len = 0;
      i_req1_valid = 1'b1; i_req1_data = 8'h55;
      step();
      i_req1_valid = 1'b0;
      for (int i = 0; i < TMO + GAP + 4; i++) step();
      n_cmp++;
      if (s_tmo !== 1'b1) begin n_bad++; $display("FAIL rst_tmo_pre: got %b want 1", s_tmo); end
      busy_len = 10;
      i_req0_valid = 1'b1; i_req0_data = 8'hC3; i_uart_rxne = 1'b1; i_uart_data_rx = 8'h3C;
      step();
      n_cmp++;
      if ({s_r1, s_r0} !== 2'b01) begin n_bad++; $display("FAIL rst_accept: got %b%b want 01", s_r1, s_r0); end
      i_req0_valid = 1'b0; i_uart_rxne = 1'b0;
      for (int i = 0; i < 4; i++) step();
      n_cmp++;
      if ({s_str, s_rxv, s_data} !== {2'b11, 8'hC3}) begin n_bad++; $display("FAIL rst_frame_before: got str%b v%b %h want str1 v1 c3", s_str, s_rxv, s_data); end
      i_rst = 1'b0; i_req1_valid = 1'b1;
      step();
      n_cmp++;
      if ({s_r1, s_r0} !== 2'b00) begin n_bad++; $display("FAIL rst_no_ready: got %b%b want 00", s_r1, s_r0); end
      i_rst = 1'b1; i_req1_valid = 1'b0;
      step();
      n_cmp++;
      if ({s_str, s_r1, s_r0, s_owner, s_rxv, s_ovr, s_tmo} !== 7'b0) begin
         n_bad++; $display("FAIL rst_mid_flags: got %b want 0000000", {s_str, s_r1, s_r0, s_owner, s_rxv, s_ovr, s_tmo});
      end
      n_cmp++;
      if ({s_data, s_rxd} !== 16'h0000) begin n_bad++; $display("FAIL rst_mid_data: got %h/%h want 00/00", s_data, s_rxd); end
   endtask

   initial begin
      i_rst = 1'b0; i_en = 1'b1; i_req0_valid = 1'b0; i_req1_valid = 1'b0;
      i_req0_data = 8'h00; i_req1_data = 8'h00; i_uart_busy_tx = 1'b0;
      i_uart_rxne = 1'b0; i_uart_data_rx = 8'h00; i_rx_ack = 1'b0;
      test_reset();
      test_single_req();
      test_round_robin();
      test_timeout();
      test_random_tx();
      test_rx();
      test_enable();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion want finish before 2ms");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter TMO_CYCLES, default 16: max cycles in ISSUE waiting for i_uart_busy_tx before abort.
REQ-002 SHALL have parameter GAP_CYCLES, default 2: idle cycles with str_tx low between frames; legal range 1..15.
REQ-003 SHALL have port i_clk  in  1  system clock; all logic on rising edge.
REQ-004 SHALL have port i_rst  in  1  reset, synchronous, active-low; clock i_clk.
REQ-005 SHALL have port i_en  in  1  block enable; forwarded to UART enable.
REQ-006 SHALL have ports i_req0_valid / i_req1_valid  in  1  requester byte pending.
REQ-007 SHALL have ports i_req0_data / i_req1_data  in  8  requester byte.
REQ-008 SHALL have ports o_req0_ready / o_req1_ready  out  1  one-cycle accept pulse; byte taken when valid&&ready.
REQ-009 SHALL have ports o_uart_en, o_uart_str_tx  out  1, and o_uart_data_tx  out  8  to the UART TX.
REQ-010 SHALL have port i_uart_busy_tx  in  1  UART transmitting.
REQ-011 SHALL have ports i_uart_rxne  in  1, i_uart_data_rx  in  8  from the UART RX.
REQ-012 SHALL have ports o_rx_valid  out  1, o_rx_data  out  8, i_rx_ack  in  1, o_rx_ovr  out  1  RX holding register.
REQ-013 SHALL have ports o_owner  out  1  (requester of in-flight byte), o_tmo_err  out  1  (sticky timeout).

Function
REQ-014 SHALL implement FSM IDLE, ISSUE, WAIT_DONE, GAP; o_uart_en = i_en.
REQ-015 IDLE: if any valid, SHALL select winner, pulse its ready that cycle, latch data into o_uart_data_tx and winner into o_owner, go ISSUE next cycle.
REQ-016 Arbitration SHALL be round-robin: with both valid, grant the requester not served last; single valid always granted.
REQ-017 ISSUE: SHALL drive o_uart_str_tx=1; busy=1 -> WAIT_DONE; else count; after TMO_CYCLES cycles without busy -> set o_tmo_err, drop str_tx, go GAP (byte dropped).
REQ-018 WAIT_DONE: SHALL hold str_tx=1 and data stable; first cycle busy=0 -> GAP with str_tx=0 from next cycle.
REQ-019 GAP: SHALL hold str_tx=0 for exactly GAP_CYCLES cycles, then IDLE; no ready pulse outside IDLE.
REQ-020 o_uart_data_tx SHALL be constant from latch until next accept.
REQ-021 RX: SHALL capture one byte per rising edge of i_uart_rxne (rxne may stay high 2 consecutive cycles; no double capture).
REQ-022 Capture with o_rx_valid=0, or with i_rx_ack=1 same cycle: load o_rx_data, o_rx_valid=1, no overrun.
REQ-023 Capture with o_rx_valid=1 and no ack: overwrite o_rx_data, set o_rx_ovr.
REQ-024 i_rx_ack with no capture SHALL clear o_rx_valid and o_rx_ovr next cycle.
REQ-025 i_en=0 SHALL force FSM IDLE, str_tx=0, readies 0, drop in-flight byte, clear RX valid/ovr; o_tmo_err, RR pointer and data regs keep value.

Reset
REQ-026 On i_rst=0 at posedge: FSM IDLE; o_uart_str_tx, o_uart_data_tx, readies, o_owner, o_rx_valid, o_rx_data, o_rx_ovr, o_tmo_err, counters all 0; RR pointer = requester 1 last served (req0 wins first tie).
REQ-027 Reset mid-frame SHALL drop str_tx next cycle; no ready pulse in reset cycle.

Configuration
REQ-028 Macro UART_TX_ARB_PRIO_EN: defined -> fixed priority, req0 always wins ties, RR pointer removed; undefined -> round-robin per REQ-016.

Verification
REQ-029 req0 valid 0x41 alone, busy model 20 cycles -> ready0 pulse, str_tx high through busy, low GAP_CYCLES=2, data 0x41 stable.
REQ-030 req0 0x10 and req1 0x20 continuously valid -> grants 0,1,0,1 (macro off); 0,0,0 (macro on).
REQ-031 busy tied 0, req1 0x55 -> str_tx high 16 cycles, o_tmo_err=1, FSM back to IDLE after 2-cycle gap.
REQ-032 rxne high 2 cycles data 0x33, no ack -> o_rx_valid=1, data 0x33, ovr 0; second pulse 0x44 no ack -> data 0x44, ovr=1.
REQ-033 ack coincident with new rxne edge 0x77 -> valid stays 1, data 0x77, ovr 0.
REQ-034 i_rst low during WAIT_DONE -> next cycle str_tx=0, all outputs 0, tmo_err 0.
